aq_f_spsram_2048x32_ctrl: RTL and testbench

Access controller that sits directly upstream of the 2048x32 single-port SRAM wrapper. It converts a valid/ready request stream (read or byte-masked write) into the SRAM's active-low CEN/GWEN/WEN pin protocol. It captures the synchronous read data into a response FIFO with backpressure. Optionally, it zero-initialises the whole array after reset.

---
 rtl/aq_f_spsram_2048x32_ctrl.sv | 152 +++++++++++++++
 tb/tb_aq_f_spsram_2048x32_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_f_spsram_2048x32_ctrl.sv
// Request/response access controller for the 2048x32 single-port SRAM wrapper.
// Optional post-reset zero fill of the array is enabled by AQ_F_SPSRAM_CTRL_INIT_EN.
`timescale 1ns/1ps

module aq_f_spsram_2048x32_ctrl #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned RSP_DEPTH  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_be,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [31:0]           rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] A,
  output logic                  CEN,
  output logic                  GWEN,
  output logic [31:0]           WEN,
  output logic [31:0]           D,
  input  logic [31:0]           Q
);

  localparam int unsigned PtrW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(RSP_DEPTH - 1);
  localparam logic [CntW:0]   DepthC  = (CntW + 1)'(RSP_DEPTH);

  logic            run;
  logic            accept;
  logic            push;
  logic            pop;
  logic            rd_inflight_q;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW:0]   occupancy;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [31:0]     mem_q [RSP_DEPTH];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

`ifdef AQ_F_SPSRAM_CTRL_INIT_EN
  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == StInit) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (&init_cnt_q) begin
        state_d = StRun;
      end
    end
  end

  assign run       = (state_q == StRun) && !RST;
  assign init_done = run;
`else
  assign run       = !RST;
  assign init_done = !RST;
`endif

  assign rsp_vld   = (count_q != '0);
  assign rsp_rdata = mem_q[rd_ptr_q];
  assign pop       = rsp_vld && rsp_rdy;
  assign push      = rd_inflight_q;

  // Reads are only admitted while a FIFO slot is guaranteed for their data.
  always_comb begin
    occupancy = {1'b0, count_q} + {{CntW{1'b0}}, rd_inflight_q} - {{CntW{1'b0}}, pop};
    req_rdy   = run && (req_wr || (occupancy < DepthC));
    accept    = req_vld && req_rdy;
  end

  always_comb begin
    CEN  = 1'b1;
    GWEN = 1'b1;
    WEN  = '1;
    A    = '0;
    D    = '0;
`ifdef AQ_F_SPSRAM_CTRL_INIT_EN
    if (state_q == StInit && !RST) begin
      CEN  = 1'b0;
      GWEN = 1'b0;
      WEN  = '0;
      A    = init_cnt_q;
    end
`endif
    if (accept) begin
      CEN = 1'b0;
      A   = req_addr;
      D   = req_wdata;
      if (req_wr) begin
        GWEN = 1'b0;
        for (int i = 0; i < 4; i++) begin
          WEN[8*i+:8] = {8{~req_be[i]}};
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_inflight_q <= 1'b0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < int'(RSP_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_inflight_q <= accept && !req_wr;
      count_q       <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= Q;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

endmodule

// File: tb/tb_aq_f_spsram_2048x32_ctrl.sv
// Directed bench for aq_f_spsram_2048x32_ctrl with a behavioural single-port SRAM.
`timescale 1ns/1ps

module tb_aq_f_spsram_2048x32_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_vld, req_rdy, req_wr;
  logic [10:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_vld, rsp_rdy;
  logic [31:0] rsp_rdata;
  logic        init_done;
  logic [10:0] A;
  logic        CEN, GWEN;
  logic [31:0] WEN, D;
  logic [31:0] Q = '0;

  int checks = 0;
  int errors = 0;

  aq_f_spsram_2048x32_ctrl #(.ADDR_WIDTH(11), .RSP_DEPTH(2)) dut (
    .CLK(CLK), .RST(RST), .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_vld(rsp_vld),
    .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .init_done(init_done), .A(A), .CEN(CEN),
    .GWEN(GWEN), .WEN(WEN), .D(D), .Q(Q)
  );

  always #5 CLK = ~CLK;

  // Behavioural SRAM: bit-masked write, read data one cycle later.
  bit [31:0] sram [2048];
  always @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) sram[A] <= (sram[A] & WEN) | (D & ~WEN);
      else       Q <= sram[A];
    end
  end

  always @(negedge CLK) begin
    if (!RST && dut.count_q > 2) begin
      errors++;
      $display("FAIL fifo_overflow: count %0d exceeds depth 2", dut.count_q);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          vld;
    bit          wr;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          e_cen;
    bit          e_gwen;
    logic [31:0] e_wen;
    bit          e_rvld;
    logic [31:0] e_rdata;
  } vec_t;

  function automatic vec_t wr_v(logic [10:0] a, logic [31:0] d, logic [3:0] be,
                                logic [31:0] wen);
    vec_t v;
    v.vld = 1; v.wr = 1; v.addr = a; v.wdata = d; v.be = be;
    v.e_cen = 0; v.e_gwen = 0; v.e_wen = wen; v.e_rvld = 0; v.e_rdata = '0;
    return v;
  endfunction

  function automatic vec_t rd_v(logic [10:0] a, bit rv, logic [31:0] rd);
    vec_t v;
    v.vld = 1; v.wr = 0; v.addr = a; v.wdata = '0; v.be = '0;
    v.e_cen = 0; v.e_gwen = 1; v.e_wen = '1; v.e_rvld = rv; v.e_rdata = rd;
    return v;
  endfunction

  function automatic vec_t idle_v(bit rv, logic [31:0] rd);
    vec_t v;
    v.vld = 0; v.wr = 0; v.addr = '0; v.wdata = '0; v.be = '0;
    v.e_cen = 1; v.e_gwen = 1; v.e_wen = '1; v.e_rvld = rv; v.e_rdata = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input bit vld, input bit wr, input logic [10:0] addr,
                       input logic [31:0] wd, input logic [3:0] be, input bit rr);
    req_vld = vld; req_wr = wr; req_addr = addr; req_wdata = wd; req_be = be; rsp_rdy = rr;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_read(input string name, input logic [10:0] addr,
                             input logic [31:0] exp);
    drive(1, 0, addr, '0, '0, 1);
    #1 chk({name, "_rdy"}, {31'd0, req_rdy}, 32'd1);
    tick;
    drive(0, 0, '0, '0, '0, 1);
    #1 chk({name, "_vld_early"}, {31'd0, rsp_vld}, 32'd0);
    tick;
    chk({name, "_vld"}, {31'd0, rsp_vld}, 32'd1);
    chk({name, "_data"}, rsp_rdata, exp);
    tick;
  endtask

  vec_t tbl [30];
  int   bad;

  initial begin
    tbl[0] = wr_v(11'h005, 32'hDEADBEEF, 4'hF, 32'h0000_0000);
    tbl[1] = rd_v(11'h005, 0, '0);
    tbl[2] = idle_v(0, '0);
    tbl[3] = idle_v(1, 32'hDEADBEEF);
    tbl[4] = wr_v(11'h7FF, 32'h11223344, 4'hF, 32'h0000_0000);
    tbl[5] = wr_v(11'h7FF, 32'hAABBCCDD, 4'b0101, 32'hFF00_FF00);
    tbl[6] = rd_v(11'h7FF, 0, '0);
    tbl[7] = idle_v(0, '0);
    tbl[8] = idle_v(1, 32'h11BB33DD);
    tbl[9] = wr_v(11'h7FF, 32'h0000_0000, 4'h0, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) begin
      tbl[10+i] = wr_v(11'(i), 32'hA000_0000 + 32'(i), 4'hF, 32'h0000_0000);
      tbl[18+i] = rd_v(11'(i), (i >= 2), 32'hA000_0000 + 32'(i - 2));
    end
    tbl[26] = rd_v(11'h7FF, 1, 32'hA000_0006);
    tbl[27] = idle_v(1, 32'hA000_0007);
    tbl[28] = idle_v(1, 32'h11BB33DD);
    tbl[29] = idle_v(0, '0);

    // Reset state with a request already pending.
    drive(1, 0, 11'h123, '0, '0, 1);
    RST = 1'b1;
    #2;
    chk("rst_req_rdy", {31'd0, req_rdy}, 32'd0);
    chk("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_cen", {31'd0, CEN}, 32'd1);
    chk("rst_gwen", {31'd0, GWEN}, 32'd1);
    chk("rst_wen", WEN, 32'hFFFF_FFFF);
    chk("rst_a", {21'd0, A}, 32'd0);
    chk("rst_d", D, 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1 RST = 1'b0;
    #1;

`ifdef AQ_F_SPSRAM_CTRL_INIT_EN
    bad = 0;
    for (int i = 0; i < 2048; i++) begin
      if (req_rdy || init_done || CEN || GWEN || WEN != 32'd0 || D != 32'd0 || A != 11'(i))
        bad++;
      tick;
    end
    chk("init_sweep_bad_cycles", bad, 0);
    chk("init_done_after_sweep", {31'd0, init_done}, 32'd1);
    expect_read("init_rd_123", 11'h123, 32'h0000_0000);
`else
    chk("init_done_no_init", {31'd0, init_done}, 32'd1);
    chk("req_rdy_after_rst", {31'd0, req_rdy}, 32'd1);
    drive(0, 0, '0, '0, '0, 1);
    tick;
`endif

    for (int i = 0; i < 30; i++) begin
      drive(tbl[i].vld, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, 1);
      #1;
      chk($sformatf("v%0d_req_rdy", i), {31'd0, req_rdy}, 32'd1);
      chk($sformatf("v%0d_cen", i), {31'd0, CEN}, {31'd0, tbl[i].e_cen});
      chk($sformatf("v%0d_gwen", i), {31'd0, GWEN}, {31'd0, tbl[i].e_gwen});
      chk($sformatf("v%0d_wen", i), WEN, tbl[i].e_wen);
      chk($sformatf("v%0d_a", i), {21'd0, A}, tbl[i].e_cen ? 32'd0 : {21'd0, tbl[i].addr});
      chk($sformatf("v%0d_d", i), D, tbl[i].e_cen ? 32'd0 : tbl[i].wdata);
      chk($sformatf("v%0d_rsp_vld", i), {31'd0, rsp_vld}, {31'd0, tbl[i].e_rvld});
      if (tbl[i].e_rvld) chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, tbl[i].e_rdata);
      tick;
    end

    // Backpressure: only two reads fit, writes still pass, then drain in order.
    drive(1, 0, 11'd1, '0, '0, 0);
    #1 chk("bp_rd1_rdy", {31'd0, req_rdy}, 32'd1);
    tick;
    drive(1, 0, 11'd2, '0, '0, 0);
    #1 chk("bp_rd2_rdy", {31'd0, req_rdy}, 32'd1);
    tick;
    drive(1, 0, 11'd3, '0, '0, 0);
    #1 chk("bp_rd3_blocked", {31'd0, req_rdy}, 32'd0);
    chk("bp_rd3_cen", {31'd0, CEN}, 32'd1);
    chk("bp_stall_vld0", {31'd0, rsp_vld}, 32'd1);
    chk("bp_stall_data0", rsp_rdata, 32'hA000_0001);
    tick;
    #1 chk("bp_rd3_still_blocked", {31'd0, req_rdy}, 32'd0);
    chk("bp_stall_vld1", {31'd0, rsp_vld}, 32'd1);
    chk("bp_stall_data1", rsp_rdata, 32'hA000_0001);
    tick;
    drive(1, 1, 11'h100, 32'h5A5A5A5A, 4'hF, 0);
    #1 chk("bp_wr_rdy", {31'd0, req_rdy}, 32'd1);
    chk("bp_wr_cen", {31'd0, CEN}, 32'd0);
    chk("bp_wr_gwen", {31'd0, GWEN}, 32'd0);
    tick;
    drive(1, 0, 11'd3, '0, '0, 1);
    #1 chk("bp_rd3_rdy", {31'd0, req_rdy}, 32'd1);
    chk("bp_drain_data1", rsp_rdata, 32'hA000_0001);
    tick;
    drive(1, 0, 11'd4, '0, '0, 1);
    #1 chk("bp_rd4_rdy", {31'd0, req_rdy}, 32'd1);
    chk("bp_drain_data2", rsp_rdata, 32'hA000_0002);
    tick;
    drive(0, 0, '0, '0, '0, 1);
    #1 chk("bp_drain_vld3", {31'd0, rsp_vld}, 32'd1);
    chk("bp_drain_data3", rsp_rdata, 32'hA000_0003);
    tick;
    chk("bp_drain_vld4", {31'd0, rsp_vld}, 32'd1);
    chk("bp_drain_data4", rsp_rdata, 32'hA000_0004);
    tick;
    chk("bp_empty", {31'd0, rsp_vld}, 32'd0);

    // Reset with one response queued and one read in flight.
    drive(1, 0, 11'd0, '0, '0, 0);
    tick;
    drive(1, 0, 11'd1, '0, '0, 0);
    tick;
    drive(1, 0, 11'd2, '0, '0, 0);
    RST = 1'b1;
    #1;
    chk("mid_rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
    chk("mid_rst_cen", {31'd0, CEN}, 32'd1);
    chk("mid_rst_req_rdy", {31'd0, req_rdy}, 32'd0);
    chk("mid_rst_init_done", {31'd0, init_done}, 32'd0);
    tick;
    drive(0, 0, '0, '0, '0, 1);
    tick;
    RST = 1'b0;
    bad = 0;
    for (int i = 0; i < 3000 && !init_done; i++) begin
      if (rsp_vld) bad++;
      tick;
    end
    chk("post_rst_ready", {31'd0, init_done}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (rsp_vld) bad++;
      tick;
    end
    chk("post_rst_no_stale_rsp", bad, 0);
`ifdef AQ_F_SPSRAM_CTRL_INIT_EN
    expect_read("post_rst_rd_100", 11'h100, 32'h0000_0000);
`else
    expect_read("post_rst_rd_100", 11'h100, 32'h5A5A5A5A);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
